// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the sequencer state encoding.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: 64-bit product plus quotient/remainder
// with truncate-toward-zero signed semantics and a divide-by-zero flag.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn_mul_s;
  logic        sgn_div_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  // Multiply: the low 64 bits of a 64x64 product of extended operands is the
  // correct result for both signed and unsigned forms.
  always_comb begin
    sgn_mul_s = (op == MD_MULT);
    a_ext_s   = {{32{sgn_mul_s & rs[31]}}, rs};
    b_ext_s   = {{32{sgn_mul_s & rt[31]}}, rt};
    prod      = a_ext_s * b_ext_s;
  end

  // Divide on magnitudes, then restore signs; a zero divisor is replaced by
  // one so the divider never sees it, and the flag suppresses the commit.
  always_comb begin
    sgn_div_s = (op == MD_DIV);
    div_zero  = (rt == 32'd0);
    neg_a_s   = sgn_div_s & rs[31];
    neg_b_s   = sgn_div_s & rt[31];
    mag_a_s   = neg_a_s ? (~rs + 32'd1) : rs;
    if (div_zero) begin
      mag_b_s = 32'd1;
    end else begin
      mag_b_s = neg_b_s ? (~rt + 32'd1) : rt;
    end
    q_mag_s = mag_a_s / mag_b_s;
    r_mag_s = mag_a_s % mag_b_s;
    quot    = (neg_a_s ^ neg_b_s) ? (~q_mag_s + 32'd1) : q_mag_s;
    rem     = neg_a_s ? (~r_mag_s + 32'd1) : r_mag_s;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer and HI/LO owner: holds busy for a fixed latency,
// then commits the pending result; also drives the D-stage stall request.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  mdu_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [31:0]      pend_hi_r, pend_hi_nxt_s;
  logic [31:0]      pend_lo_r, pend_lo_nxt_s;
  logic             pend_dz_r, pend_dz_nxt_s;
  logic [31:0]      hi_r, hi_nxt_s;
  logic [31:0]      lo_r, lo_nxt_s;
  logic             busy_r;
  logic             start_eff_s;
  logic [63:0]      prod_s;
  logic [31:0]      quot_s;
  logic [31:0]      rem_s;
  logic             div_zero_s;

  mdu_arith u_arith (
    .op       (op),
    .rs       (rs),
    .rt       (rt),
    .prod     (prod_s),
    .quot     (quot_s),
    .rem      (rem_s),
    .div_zero (div_zero_s)
  );

  // Qualified start and stall; stall covers the start cycle itself.
  always_comb begin
    start_eff_s = start & ~flush & ~busy_r & (op <= MD_MTLO);
    stall       = d_uses_md & (busy_r | start_eff_s);
  end

  // Next-state, counter, pending and HI/LO update logic.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_dz_nxt_s = pend_dz_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start_eff_s) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              pend_hi_nxt_s = prod_s[63:32];
              pend_lo_nxt_s = prod_s[31:0];
              pend_dz_nxt_s = 1'b0;
              cnt_nxt_s     = CNT_W'(MULT_CYCLES - 1);
              state_nxt_s   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_nxt_s = rem_s;
              pend_lo_nxt_s = quot_s;
              pend_dz_nxt_s = div_zero_s;
              cnt_nxt_s     = CNT_W'(DIV_CYCLES - 1);
              state_nxt_s   = ST_BUSY;
            end
            MD_MTHI: hi_nxt_s = rs;
            MD_MTLO: lo_nxt_s = rs;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == '0) begin
          state_nxt_s = ST_IDLE;
          if (!pend_dz_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_dz_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_dz_r <= pend_dz_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      busy_r    <= (state_nxt_s == ST_BUSY);
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of HI/LO and busy.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_dz;
  int          m_left;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .flush     (flush),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
    m_dz = 1'b0; m_left = 0;
  endtask

  // One clock of stimulus, called at a falling edge; returns at the next one.
  task automatic step(input logic st, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic du);
    logic         acc;
    longint       sa, sb, sq, sr;
    logic [63:0]  p;
    start = st; op = o; rs = a; rt = b; flush = fl; d_uses_md = du;
    #1;
    acc = st && !fl && (m_left == 0) && (o <= 3'd5);
    check_eq("stall", {63'd0, stall}, {63'd0, du && (m_left != 0 || acc)});
    @(posedge clk);
    if (m_left != 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (acc) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
        3'd0: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; m_dz = 1'b0; m_left = 5; end
        3'd1: begin p = {32'd0, a} * {32'd0, b}; m_phi = p[63:32]; m_plo = p[31:0]; m_dz = 1'b0; m_left = 5; end
        3'd2: begin
          m_dz = (b == 32'd0); m_left = 10;
          if (!m_dz) begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
        end
        3'd3: begin
          m_dz = (b == 32'd0); m_left = 10;
          if (!m_dz) begin m_plo = a / b; m_phi = a % b; end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
    #1;
    check_eq("busy", {63'd0, busy}, {63'd0, m_left != 0});
    check_eq("hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("lo", {32'd0, lo}, {32'd0, m_lo});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic du);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, du);
  endtask

  // Asserts reset between edges and checks the outputs clear before any edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    model_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    flush = 1'b0; d_uses_md = 1'b0;
    @(negedge clk);
    async_reset();
    idle(2, 1'b0);

    // MULT -2*3 with a dependent D instruction, then MULTU same operands
    step(1'b1, 3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b1);
    idle(6, 1'b1);
    check_eq("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check_eq("mult_lo", {32'd0, lo}, 64'hFFFFFFFA);
    step(1'b1, 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    idle(6, 1'b0);
    check_eq("multu_hi", {32'd0, hi}, 64'h00000002);
    check_eq("multu_lo", {32'd0, lo}, 64'hFFFFFFFA);

    // DIV -7/2 with flush pulsed mid-operation, then DIVU by zero
    step(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(7, 1'b0);
    check_eq("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check_eq("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
    step(1'b1, 3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
    idle(11, 1'b0);
    check_eq("divz_lo", {32'd0, lo}, 64'hFFFFFFFD);

    // Overflow case, then a start while busy is ignored
    step(1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    step(1'b1, 3'd4, 32'h000000AA, 32'd0, 1'b0, 1'b1);
    idle(9, 1'b0);
    check_eq("ovf_lo", {32'd0, lo}, 64'h80000000);
    check_eq("ovf_hi", {32'd0, hi}, 64'h0);

    // Flushed start dropped; MTLO immediate
    step(1'b1, 3'd0, 32'd2, 32'd3, 1'b1, 1'b1);
    step(1'b1, 3'd5, 32'h00001234, 32'd0, 1'b0, 1'b0);
    check_eq("mtlo", {32'd0, lo}, 64'h1234);

    // Reset at busy cycle 3 of a DIV: nothing commits afterwards
    step(1'b1, 3'd3, 32'd50, 32'd7, 1'b0, 1'b0);
    idle(2, 1'b0);
    async_reset();
    idle(12, 1'b0);
    check_eq("nocommit_lo", {32'd0, lo}, 64'h0);

    // Random traffic, including invalid ops, flushes and zero divisors
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom, b,
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    idle(12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
